// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake bundle for the bit-serial adder: operands in, result and status out.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, WIDTH RUN cycles then a one-cycle DONE.
// Result ports update only on DONE entry; start is ignored while RUN.
module serial_fa_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_c;
  logic [WIDTH-1:0] sr_shift;

  serial_fa_slice u_fa (
    .a_i (sa_q[0]),
    .b_i (sb_q[0]),
    .c_i (cy_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sr_shift            = sr_q >> 1;
    sr_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          cy_d    = bus.c_in;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        sr_d  = sr_shift;
        cy_d  = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // cy_q is the carry into the MSB on this last bit.
          sum_d   = sr_shift;
          cout_d  = fa_c;
          ovf_d   = cy_q ^ fa_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = cout_q;
  assign bus.ovf   = ovf_q;
endmodule
